// File: rtl/mpc_alu_exec_pkg.sv
// Shared ALU-op encodings and execute-unit types.
// The `ALU_* macros are shared with the ID-stage ALU-op decoder. The package mirrors them as
// typed constants for the execute unit and its bench.
// No ports: this file holds only definitions.

`ifndef MPC_ALU_DEFINES
`define MPC_ALU_DEFINES
`define ALU_OP_WIDTH 5
`define ALU_INT_ADD  5'h00
`define ALU_INT_SUB  5'h01
`define ALU_INT_AND  5'h02
`define ALU_INT_SLT  5'h03
`define ALU_INT_MUL  5'h04
`define ALU_INT_DIV  5'h05
`define ALU_SFP_ADD  5'h08
`define ALU_SFP_MUL  5'h09
`define ALU_SFP_DIV  5'h0A
`define ALU_SFP_CMP  5'h0B
`define ALU_SYS_NOP  5'h1F
`define MPC_EX_IDLE  2'd0
`define MPC_EX_ITER  2'd1
`define MPC_EX_FIX   2'd2
`endif

package mpc_alu_exec_pkg;

  localparam int unsigned AluOpWidth = `ALU_OP_WIDTH;

  typedef logic [AluOpWidth-1:0] aluOp_t;

  localparam aluOp_t AluIntAdd = `ALU_INT_ADD;
  localparam aluOp_t AluIntSub = `ALU_INT_SUB;
  localparam aluOp_t AluIntAnd = `ALU_INT_AND;
  localparam aluOp_t AluIntSlt = `ALU_INT_SLT;
  localparam aluOp_t AluIntMul = `ALU_INT_MUL;
  localparam aluOp_t AluIntDiv = `ALU_INT_DIV;
  localparam aluOp_t AluSfpAdd = `ALU_SFP_ADD;
  localparam aluOp_t AluSfpMul = `ALU_SFP_MUL;
  localparam aluOp_t AluSfpDiv = `ALU_SFP_DIV;
  localparam aluOp_t AluSfpCmp = `ALU_SFP_CMP;
  localparam aluOp_t AluSysNop = `ALU_SYS_NOP;

  typedef enum logic [1:0] {
    StIdle = `MPC_EX_IDLE,
    StIter = `MPC_EX_ITER,
    StFix  = `MPC_EX_FIX
  } exState_e;

endpackage

// File: rtl/mpc_muldiv_iter.sv
// Unsigned iterative multiplier / divider, one bit per clock edge for DATA_W edges.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   iStart           load operands and begin (ignored while iAbort is high)
//   iAbort           drop any in-flight operation
//   iDiv             0: shift-add multiply, 1: restoring divide
//   iOpA, iOpB       unsigned multiplicand/multiplier or dividend/divisor
//   oBusy            iterating
//   oDone            high during the cycle whose closing edge performs the last step
//   oHi, oLo         MUL {high, low} product; DIV remainder, quotient

module mpc_muldiv_iter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iDiv,
  input  logic [DATA_W-1:0] iOpA,
  input  logic [DATA_W-1:0] iOpB,
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oHi,
  output logic [DATA_W-1:0] oLo
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] hiQ, hiD, loQ, loD, bQ, bD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic              busyQ, busyD, divQ, divD;

  logic [DATA_W:0]   mulSum;
  logic [DATA_W:0]   divShift;
  logic [DATA_W:0]   divDiff;

  assign mulSum   = {1'b0, hiQ} + {1'b0, bQ};
  assign divShift = {hiQ, loQ[DATA_W-1]};
  // Partial remainder stays below the divisor, so a borrow shows up in the top bit.
  assign divDiff  = divShift - {1'b0, bQ};

  always_comb begin
    hiD   = hiQ;
    loD   = loQ;
    bD    = bQ;
    cntD  = cntQ;
    busyD = busyQ;
    divD  = divQ;
    if (iAbort) begin
      busyD = 1'b0;
    end else if (iStart) begin
      hiD   = '0;
      loD   = iOpA;
      bD    = iOpB;
      divD  = iDiv;
      cntD  = '0;
      busyD = 1'b1;
    end else if (busyQ) begin
      if (divQ) begin
        loD = {loQ[DATA_W-2:0], ~divDiff[DATA_W]};
        hiD = divDiff[DATA_W] ? divShift[DATA_W-1:0] : divDiff[DATA_W-1:0];
      end else if (loQ[0]) begin
        {hiD, loD} = {mulSum, loQ[DATA_W-1:1]};
      end else begin
        {hiD, loD} = {1'b0, hiQ, loQ[DATA_W-1:1]};
      end
      cntD = cntQ + 1'b1;
      if (cntQ == LastCnt) begin
        busyD = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hiQ   <= '0;
      loQ   <= '0;
      bQ    <= '0;
      cntQ  <= '0;
      busyQ <= 1'b0;
      divQ  <= 1'b0;
    end else begin
      hiQ   <= hiD;
      loQ   <= loD;
      bQ    <= bD;
      cntQ  <= cntD;
      busyQ <= busyD;
      divQ  <= divD;
    end
  end

  assign oBusy = busyQ;
  assign oDone = busyQ & ~iAbort & (cntQ == LastCnt);
  assign oHi   = hiQ;
  assign oLo   = loQ;

endmodule

// File: rtl/mpc_alu_exec.sv
// Integer execute unit. ADD/SUB/AND/SLT/NOP finish one cycle after acceptance. MUL/DIV
// iterate in mpc_muldiv_iter on magnitudes, and signs are applied in the FIX state.
// SFP and unknown codes complete at once with oUnsupported.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   iValid / oReady         request handshake; oReady is high only in IDLE
//   iFlush                  cancel in-flight op, block acceptance this cycle
//   iALUOperation           op code
//   iImmediate, iImm        operand B = sign-extended iImm when iImmediate
//   iSign                   signed semantics
//   iOpA, iOpB              register operands
//   oDone                   1-cycle result strobe
//   oResult, oHi            result low word / MUL high word or DIV remainder
//   oOverflow, oDivZero, oUnsupported   flags, valid only with oDone

module mpc_alu_exec
  import mpc_alu_exec_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iFlush,
  input  aluOp_t            iALUOperation,
  input  logic              iImmediate,
  input  logic              iSign,
  input  logic [DATA_W-1:0] iOpA,
  input  logic [DATA_W-1:0] iOpB,
  input  logic [IMM_W-1:0]  iImm,
  output logic              oDone,
  output logic [DATA_W-1:0] oResult,
  output logic [DATA_W-1:0] oHi,
  output logic              oOverflow,
  output logic              oDivZero,
  output logic              oUnsupported
);

  exState_e          stateQ, stateD;
  logic [DATA_W-1:0] resultQ, resultD, hiQ, hiD;
  logic              doneQ, doneD, ovfQ, ovfD, dzQ, dzD, unsQ, unsD;
  logic              negLoQ, negLoD, negHiQ, negHiD, opDivQ, opDivD;

  logic [DATA_W-1:0]   opB, absA, absB, sum, diff;
  logic                sA, sB, accept, sltBit, iterStart;
  logic                iterBusy, iterDone;
  logic [DATA_W-1:0]   iterHi, iterLo;
  logic [2*DATA_W-1:0] prod;

  assign opB    = iImmediate ? {{(DATA_W - IMM_W){iImm[IMM_W-1]}}, iImm} : iOpB;
  assign sA     = iSign & iOpA[DATA_W-1];
  assign sB     = iSign & opB[DATA_W-1];
  assign absA   = sA ? (~iOpA + 1'b1) : iOpA;
  assign absB   = sB ? (~opB + 1'b1) : opB;
  assign sum    = iOpA + opB;
  assign diff   = iOpA - opB;
  assign sltBit = iSign ? ($signed(iOpA) < $signed(opB)) : (iOpA < opB);
  assign accept = iValid & (stateQ == StIdle) & ~iFlush;
  assign prod   = {iterHi, iterLo};

  mpc_muldiv_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) uIter (
    .clk    (clk),
    .resetn (resetn),
    .iStart (iterStart),
    .iAbort (iFlush),
    .iDiv   (iALUOperation == AluIntDiv),
    .iOpA   (absA),
    .iOpB   (absB),
    .oBusy  (iterBusy),
    .oDone  (iterDone),
    .oHi    (iterHi),
    .oLo    (iterLo)
  );

  always_comb begin
    stateD    = stateQ;
    resultD   = resultQ;
    hiD       = hiQ;
    doneD     = 1'b0;
    ovfD      = 1'b0;
    dzD       = 1'b0;
    unsD      = 1'b0;
    negLoD    = negLoQ;
    negHiD    = negHiQ;
    opDivD    = opDivQ;
    iterStart = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          doneD   = 1'b1;
          resultD = '0;
          hiD     = '0;
          case (iALUOperation)
            AluIntAdd: begin
              resultD = sum;
              ovfD    = iSign & (iOpA[DATA_W-1] == opB[DATA_W-1])
                        & (sum[DATA_W-1] != iOpA[DATA_W-1]);
            end
            AluIntSub: begin
              resultD = diff;
              ovfD    = iSign & (iOpA[DATA_W-1] != opB[DATA_W-1])
                        & (diff[DATA_W-1] != iOpA[DATA_W-1]);
            end
            AluIntAnd: resultD = iOpA & opB;
            AluIntSlt: resultD = {{(DATA_W - 1){1'b0}}, sltBit};
            AluIntMul: begin
              doneD     = 1'b0;
              resultD   = resultQ;
              hiD       = hiQ;
              iterStart = 1'b1;
              negLoD    = sA ^ sB;
              opDivD    = 1'b0;
              stateD    = StIter;
            end
            AluIntDiv: begin
              if (opB == '0) begin
                dzD     = 1'b1;
                resultD = '1;
                hiD     = iOpA;
              end else begin
                doneD     = 1'b0;
                resultD   = resultQ;
                hiD       = hiQ;
                iterStart = 1'b1;
                negLoD    = sA ^ sB;
                negHiD    = sA;
                opDivD    = 1'b1;
                stateD    = StIter;
              end
            end
            AluSysNop: ;
            default:   unsD = 1'b1;
          endcase
        end
      end
      StIter: begin
        // Leaving on !iterBusy is defensive; the iterator is busy for the whole ITER stay.
        if (iFlush || !iterBusy) begin
          stateD = StIdle;
        end else if (iterDone) begin
          stateD = StFix;
        end
      end
      StFix: begin
        stateD = StIdle;
        if (!iFlush) begin
          doneD = 1'b1;
          if (opDivQ) begin
            resultD = negLoQ ? (~iterLo + 1'b1) : iterLo;
            hiD     = negHiQ ? (~iterHi + 1'b1) : iterHi;
          end else begin
            {hiD, resultD} = negLoQ ? (~prod + 1'b1) : prod;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ  <= StIdle;
      resultQ <= '0;
      hiQ     <= '0;
      doneQ   <= 1'b0;
      ovfQ    <= 1'b0;
      dzQ     <= 1'b0;
      unsQ    <= 1'b0;
      negLoQ  <= 1'b0;
      negHiQ  <= 1'b0;
      opDivQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      resultQ <= resultD;
      hiQ     <= hiD;
      doneQ   <= doneD;
      ovfQ    <= ovfD;
      dzQ     <= dzD;
      unsQ    <= unsD;
      negLoQ  <= negLoD;
      negHiQ  <= negHiD;
      opDivQ  <= opDivD;
    end
  end

  assign oReady       = (stateQ == StIdle);
  assign oDone        = doneQ;
  assign oResult      = resultQ;
  assign oHi          = hiQ;
  assign oOverflow    = ovfQ;
  assign oDivZero     = dzQ;
  assign oUnsupported = unsQ;

endmodule

// File: tb/tb_mpc_alu_exec.sv
// Directed bench for mpc_alu_exec: vector table plus flush/reset/back-to-back sequences.

module tb_mpc_alu_exec;
  import mpc_alu_exec_pkg::*;

  logic        clk, resetn, iValid, oReady, iFlush, iImmediate, iSign;
  aluOp_t      iALUOperation;
  logic [31:0] iOpA, iOpB, oResult, oHi;
  logic [15:0] iImm;
  logic        oDone, oOverflow, oDivZero, oUnsupported;

  int checks = 0;
  int errors = 0;

  mpc_alu_exec #(
    .DATA_W (32),
    .IMM_W  (16),
    .CNT_W  (6)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .iValid        (iValid),
    .oReady        (oReady),
    .iFlush        (iFlush),
    .iALUOperation (iALUOperation),
    .iImmediate    (iImmediate),
    .iSign         (iSign),
    .iOpA          (iOpA),
    .iOpB          (iOpB),
    .iImm          (iImm),
    .oDone         (oDone),
    .oResult       (oResult),
    .oHi           (oHi),
    .oOverflow     (oOverflow),
    .oDivZero      (oDivZero),
    .oUnsupported  (oUnsupported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    aluOp_t      op;
    logic        immSel;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] expRes;
    logic [31:0] expHi;
    logic        expOvf;
    logic        expDz;
    logic        expUns;
    int          lat;   // edges after acceptance before oDone is visible
  } vec_t;

  localparam int NumVec = 16;
  vec_t vecs[NumVec];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive a request at the falling edge; returns after the accepting edge (+#1).
  task automatic issue(input aluOp_t op, input logic sign, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    iALUOperation = op;
    iSign         = sign;
    iImmediate    = 1'b0;
    iOpA          = a;
    iOpB          = b;
    iValid        = 1'b1;
    @(posedge clk);
    #1 iValid = 1'b0;
  endtask

  task automatic watchNoDone(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (oDone) seen++;
    end
  endtask

  int n, low, seen;

  initial begin
    vecs[0]  = '{AluIntAdd, 0, 1, 32'h7FFFFFFF, 32'h1, 16'h0, 32'h80000000, 32'h0, 1, 0, 0, 0};
    vecs[1]  = '{AluIntAdd, 0, 0, 32'h7FFFFFFF, 32'h1, 16'h0, 32'h80000000, 32'h0, 0, 0, 0, 0};
    vecs[2]  = '{AluIntAdd, 1, 0, 32'd10, 32'h55, 16'hFFFF, 32'd9, 32'h0, 0, 0, 0, 0};
    vecs[3]  = '{AluIntSlt, 0, 0, 32'hFFFFFFFF, 32'h1, 16'h0, 32'd0, 32'h0, 0, 0, 0, 0};
    vecs[4]  = '{AluIntSlt, 0, 1, 32'hFFFFFFFF, 32'h1, 16'h0, 32'd1, 32'h0, 0, 0, 0, 0};
    vecs[5]  = '{AluIntSub, 0, 1, 32'h80000000, 32'h1, 16'h0, 32'h7FFFFFFF, 32'h0, 1, 0, 0, 0};
    vecs[6]  = '{AluIntAnd, 0, 0, 32'hF0F0F0F0, 32'h3C3C3C3C, 16'h0, 32'h30303030, 32'h0,
                 0, 0, 0, 0};
    vecs[7]  = '{AluIntMul, 0, 1, 32'hFFFFFFFD, 32'd7, 16'h0, 32'hFFFFFFEB, 32'hFFFFFFFF,
                 0, 0, 0, 33};
    vecs[8]  = '{AluIntDiv, 0, 1, 32'hFFFFFFF9, 32'd2, 16'h0, 32'hFFFFFFFD, 32'hFFFFFFFF,
                 0, 0, 0, 33};
    vecs[9]  = '{AluIntDiv, 0, 1, 32'h1234, 32'h0, 16'h0, 32'hFFFFFFFF, 32'h1234, 0, 1, 0, 0};
    vecs[10] = '{AluIntDiv, 0, 1, 32'h80000000, 32'hFFFFFFFF, 16'h0, 32'h80000000, 32'h0,
                 0, 0, 0, 33};
    vecs[11] = '{AluIntMul, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0, 32'h00000001, 32'hFFFFFFFE,
                 0, 0, 0, 33};
    vecs[12] = '{AluIntDiv, 0, 0, 32'd100, 32'd7, 16'h0, 32'd14, 32'd2, 0, 0, 0, 33};
    vecs[13] = '{AluSfpAdd, 0, 1, 32'h5, 32'h6, 16'h0, 32'h0, 32'h0, 0, 0, 1, 0};
    vecs[14] = '{AluSysNop, 0, 0, 32'h5, 32'h6, 16'h0, 32'h0, 32'h0, 0, 0, 0, 0};
    vecs[15] = '{aluOp_t'(5'h14), 0, 0, 32'h5, 32'h6, 16'h0, 32'h0, 32'h0, 0, 0, 1, 0};

    resetn        = 1'b0;
    iValid        = 1'b0;
    iFlush        = 1'b0;
    iImmediate    = 1'b0;
    iSign         = 1'b0;
    iALUOperation = AluIntAdd;
    iOpA          = '0;
    iOpB          = '0;
    iImm          = '0;
    #1;
    check("reset_ready", 64'(oReady), 64'd1);
    check("reset_flags", {60'd0, oDone, oOverflow, oDivZero, oUnsupported}, 64'd0);
    check("reset_result", {oHi, oResult}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      iALUOperation = vecs[i].op;
      iImmediate    = vecs[i].immSel;
      iSign         = vecs[i].sign;
      iOpA          = vecs[i].a;
      iOpB          = vecs[i].b;
      iImm          = vecs[i].imm;
      iValid        = 1'b1;
      @(posedge clk);
      #1 iValid = 1'b0;
      n   = 0;
      low = 0;
      while (!oDone && n < 100) begin
        if (!oReady) low++;
        @(posedge clk);
        #1;
        n++;
      end
      check($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].lat));
      check($sformatf("v%0d_ready_low", i), 64'(low), 64'(vecs[i].lat));
      check($sformatf("v%0d_result", i), 64'(oResult), 64'(vecs[i].expRes));
      check($sformatf("v%0d_hi", i), 64'(oHi), 64'(vecs[i].expHi));
      check($sformatf("v%0d_flags", i), {61'd0, oOverflow, oDivZero, oUnsupported},
            {61'd0, vecs[i].expOvf, vecs[i].expDz, vecs[i].expUns});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pulse", i), {60'd0, oDone, oOverflow, oDivZero, oUnsupported},
            64'd0);
      check($sformatf("v%0d_hold", i), {oHi, oResult}, {vecs[i].expHi, vecs[i].expRes});
    end

    // Flush during ITER at E+10: no oDone, back to IDLE next cycle.
    issue(AluIntDiv, 1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    iFlush = 1'b1;
    @(posedge clk);
    #1 iFlush = 1'b0;
    check("flush_ready", 64'(oReady), 64'd1);
    watchNoDone(40, seen);
    check("flush_no_done", 64'(seen), 64'd0);

    // Make outputs nonzero, then reset at E+20 of a DIVU.
    issue(AluIntAdd, 1'b0, 32'd5, 32'd6);
    check("pre_reset_add", 64'(oResult), 64'd11);
    issue(AluIntDiv, 1'b0, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_mid_ready", 64'(oReady), 64'd1);
    check("rst_mid_outputs", {oHi, oResult}, 64'd0);
    check("rst_mid_flags", {60'd0, oDone, oOverflow, oDivZero, oUnsupported}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    watchNoDone(40, seen);
    check("rst_no_done", 64'(seen), 64'd0);

    // iFlush together with iValid in IDLE: request ignored.
    @(negedge clk);
    iALUOperation = AluIntMul;
    iOpA          = 32'd3;
    iOpB          = 32'd4;
    iValid        = 1'b1;
    iFlush        = 1'b1;
    @(posedge clk);
    #1;
    iValid = 1'b0;
    iFlush = 1'b0;
    check("flush_idle_ready", 64'(oReady), 64'd1);
    watchNoDone(40, seen);
    check("flush_idle_no_done", 64'(seen), 64'd0);

    // Back-to-back: ADD issued in the MUL oDone cycle.
    issue(AluIntMul, 1'b0, 32'd6, 32'd7);
    n = 0;
    while (!oDone && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_mul_latency", 64'(n), 64'd33);
    check("b2b_mul_result", {oHi, oResult}, 64'd42);
    check("b2b_ready_in_done", 64'(oReady), 64'd1);
    iALUOperation = AluIntAdd;
    iOpA          = 32'd2;
    iOpB          = 32'd3;
    iValid        = 1'b1;
    @(posedge clk);
    #1 iValid = 1'b0;
    check("b2b_add_done", 64'(oDone), 64'd1);
    check("b2b_add_result", {oHi, oResult}, 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
